microcode_seq: RTL and testbench

MICROCODE_SEQ -- requirements
Module: microcode_seq

---
 rtl/microcode_pkg.sv | 26 ++
 rtl/microcode_seq.sv | 100 ++++++++++
 tb/tb_microcode_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/microcode_pkg.sv
// Shared field layout and state encoding for the microcode sequencer.
// The ROM word is {CB_PREFIX, LAST_STEP[2:0], datapath controls[63:0]}.
package microcode_pkg;

    localparam int ROM_W    = 68;
    localparam int CTRL_W   = 64;
    localparam int OP_W     = 9;
    localparam int STEP_W   = 3;
    localparam int CB_BIT   = 67;
    localparam int LAST_MSB = 66;
    localparam int LAST_LSB = 64;
    // CB_PREFIX is consumed at decode, so the word register drops it
    localparam int WORD_W   = LAST_MSB + 1;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_CBFETCH = 2'd1,
        ST_DECODE  = 2'd2,
        ST_EXEC    = 2'd3
    } state_t;

    function automatic logic cb_prefix(input logic [ROM_W-1:0] word);
        return word[CB_BIT];
    endfunction

endpackage

// File: rtl/microcode_seq.sv
// Fetch/decode/execute sequencer driving datapath controls from an external microcode ROM.
// state   | meaning
// FETCH   | request opcode byte, page 0
// CBFETCH | request second byte after a CB prefix, page 1
// DECODE  | capture ROM word for the latched opcode
// EXEC    | step through micro-steps 0..LAST_STEP
module microcode_seq
    import microcode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              fetch_req,
    input  logic              fetch_ack,
    input  logic [7:0]        fetch_data,
    output logic              pc_inc,
    output logic [OP_W-1:0]   opcode,
    input  logic [ROM_W-1:0]  control_signals,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_valid,
    output logic [STEP_W-1:0] mstep,
    input  logic              stall
);

    state_t              r_state;
    state_t              w_state_next;
    logic [OP_W-1:0]     r_opcode;
    logic [OP_W-1:0]     w_opcode_next;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_word_next;
    logic [STEP_W-1:0]   r_mstep;
    logic [STEP_W-1:0]   w_mstep_next;
    logic                w_fetching;
    logic                w_exec;

    always_comb begin
        w_state_next  = r_state;
        w_opcode_next = r_opcode;
        w_word_next   = r_word;
        w_mstep_next  = r_mstep;
        w_fetching    = (r_state == ST_FETCH) || (r_state == ST_CBFETCH);
        w_exec        = (r_state == ST_EXEC);

        case (r_state)
            ST_FETCH: begin
                if (fetch_ack) begin
                    w_opcode_next = {1'b0, fetch_data};
                    w_state_next  = ST_DECODE;
                end
            end
            ST_CBFETCH: begin
                if (fetch_ack) begin
                    w_opcode_next = {1'b1, fetch_data};
                    w_state_next  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_word_next  = control_signals[WORD_W-1:0];
                w_mstep_next = '0;
                // a prefix seen on page 1 is not a second prefix
                if (cb_prefix(control_signals) && !r_opcode[OP_W-1])
                    w_state_next = ST_CBFETCH;
                else
                    w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (r_mstep == r_word[LAST_MSB:LAST_LSB]) begin
                        w_mstep_next = '0;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_mstep_next = r_mstep + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_opcode <= '0;
            r_word   <= '0;
            r_mstep  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_opcode <= w_opcode_next;
            r_word   <= w_word_next;
            r_mstep  <= w_mstep_next;
        end
    end

    assign fetch_req  = rst_n && w_fetching;
    assign pc_inc     = rst_n && w_fetching && fetch_ack;
    assign opcode     = r_opcode;
    assign ctrl_valid = w_exec;
    assign ctrl_out   = w_exec ? r_word[CTRL_W-1:0] : '0;
    assign mstep      = w_exec ? r_mstep : '0;

endmodule

// File: tb/tb_microcode_seq.sv
// Bench for microcode_seq: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an instruction-level model.
module tb_microcode_seq;
    import microcode_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic              fetch_ack;
    logic [7:0]        fetch_data;
    logic              pc_inc;
    logic [OP_W-1:0]   opcode;
    logic [ROM_W-1:0]  control_signals;
    logic [CTRL_W-1:0] ctrl_out;
    logic              ctrl_valid;
    logic [STEP_W-1:0] mstep;
    logic              stall;

    logic [ROM_W-1:0]  rom [0:511];

    always #5 clk = ~clk;

    assign control_signals = rom[opcode];

    microcode_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_req       (fetch_req),
        .fetch_ack       (fetch_ack),
        .fetch_data      (fetch_data),
        .pc_inc          (pc_inc),
        .opcode          (opcode),
        .control_signals (control_signals),
        .ctrl_out        (ctrl_out),
        .ctrl_valid      (ctrl_valid),
        .mstep           (mstep),
        .stall           (stall)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic a, input logic [7:0] d, input logic s, input logic r);
        @(posedge clk);
        #1;
        fetch_ack  = a;
        fetch_data = d;
        stall      = s;
        rst_n      = r;
    endtask

    // Instruction-level model: waiting for a byte, decoding, or executing with
    // a count of micro-steps still to run after the current one.
    int           m_mode;   // 0 awaiting byte, 1 decode, 2 execute
    bit           m_page;
    logic [8:0]   m_opcode;
    logic [67:0]  m_word;
    int           m_left;
    bit           m_known = 1'b0;
    logic         e_freq;
    logic         e_valid;
    logic [63:0]  e_ctrl;
    int           e_step;

    always @(negedge clk) begin
        if (m_known) begin
            e_freq  = rst_n && (m_mode == 0);
            e_valid = (m_mode == 2);
            e_ctrl  = e_valid ? m_word[63:0] : 64'd0;
            e_step  = e_valid ? (int'(m_word[66:64]) - m_left) : 0;
            chk("m_fetch_req", 64'(fetch_req), 64'(e_freq));
            chk("m_pc_inc", 64'(pc_inc), 64'(e_freq && fetch_ack));
            chk("m_ctrl_valid", 64'(ctrl_valid), 64'(e_valid));
            chk("m_ctrl_out", ctrl_out, e_ctrl);
            chk("m_mstep", 64'(mstep), 64'(e_step));
            chk("m_opcode", 64'(opcode), 64'(m_opcode));
        end
        if (!rst_n) begin
            m_known  = 1'b1;
            m_mode   = 0;
            m_page   = 1'b0;
            m_opcode = '0;
            m_word   = '0;
            m_left   = 0;
        end else if (m_known) begin
            if (m_mode == 0) begin
                if (fetch_ack) begin
                    m_opcode = {m_page, fetch_data};
                    m_mode   = 1;
                end
            end else if (m_mode == 1) begin
                m_word = rom[m_opcode];
                if (m_word[67] && !m_opcode[8]) begin
                    m_mode = 0;
                    m_page = 1'b1;
                end else begin
                    m_mode = 2;
                    m_left = int'(m_word[66:64]);
                end
            end else if (!stall) begin
                if (m_left == 0) begin
                    m_mode = 0;
                    m_page = 1'b0;
                end else begin
                    m_left = m_left - 1;
                end
            end
        end
    end

    logic [3:0] stall_pat;
    logic [5:0] s_pat;
    logic [5:0] a_pat;
    int         exp_step [6];

    initial begin
        rst_n      = 1'b0;
        fetch_ack  = 1'b0;
        fetch_data = 8'h00;
        stall      = 1'b0;
        for (int i = 0; i < 512; i++)
            rom[i] = {($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)), $urandom, $urandom};
        rom[9'h0CB][67] = 1'b1;
        rom[9'h000] = {1'b0, 3'd0, 64'h0123_4567_89AB_CDEF};
        rom[9'h137] = {1'b0, 3'd1, 64'hDEAD_BEEF_0000_1137};
        rom[9'h010] = {1'b0, 3'd3, 64'h1010_1010_1010_1010};
        rom[9'h020] = {1'b0, 3'd5, 64'h2020_2020_2020_2020};
        rom[9'h1AB] = {1'b1, 3'd0, 64'h0000_0000_0000_01AB};

        // reset, then a single-step non-prefixed instruction
        drive(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("rst_fetch_req", 64'(fetch_req), 64'd0);
        chk("rst_pc_inc", 64'(pc_inc), 64'd0);
        drive(0, 8'h00, 0, 0);
        drive(1, 8'h00, 0, 1);
        @(negedge clk);
        chk("t34_fetch_req", 64'(fetch_req), 64'd1);
        chk("t34_pc_inc", 64'(pc_inc), 64'd1);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t34_valid_n1", 64'(ctrl_valid), 64'd0);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t34_valid_n2", 64'(ctrl_valid), 64'd1);
        chk("t34_ctrl_out", ctrl_out, 64'h0123_4567_89AB_CDEF);
        chk("t34_opcode", 64'(opcode), 64'h000);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t34_valid_n3", 64'(ctrl_valid), 64'd0);
        chk("t34_refetch", 64'(fetch_req), 64'd1);

        // CB prefix followed by 0x37
        drive(1, 8'hCB, 0, 1);
        @(negedge clk);
        chk("t35_pc_inc1", 64'(pc_inc), 64'd1);
        drive(0, 8'h00, 0, 1);
        drive(1, 8'h37, 0, 1);
        @(negedge clk);
        chk("t35_cb_req", 64'(fetch_req), 64'd1);
        chk("t35_pc_inc2", 64'(pc_inc), 64'd1);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t35_opcode", 64'(opcode), 64'h137);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t35_step0", 64'(mstep), 64'd0);
        chk("t35_ctrl_out", ctrl_out, 64'hDEAD_BEEF_0000_1137);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t35_step1", 64'(mstep), 64'd1);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t35_done", 64'(ctrl_valid), 64'd0);

        // four steps with stall on step 1, stray acks during execute
        drive(1, 8'h10, 0, 1);
        drive(0, 8'h00, 0, 1);
        s_pat    = 6'b000110;
        a_pat    = 6'b101010;
        exp_step = '{0, 1, 1, 1, 2, 3};
        for (int i = 0; i < 6; i++) begin
            drive(a_pat[i], 8'hFF, s_pat[i], 1);
            @(negedge clk);
            chk("t36_mstep", 64'(mstep), 64'(exp_step[i]));
            chk("t36_valid", 64'(ctrl_valid), 64'd1);
            chk("t37_pc_inc", 64'(pc_inc), 64'd0);
            chk("t37_opcode", 64'(opcode), 64'h010);
        end
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t36_end", 64'(ctrl_valid), 64'd0);

        // reset at step 2
        drive(1, 8'h20, 0, 1);
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("t38_step2", 64'(mstep), 64'd2);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t38_valid", 64'(ctrl_valid), 64'd0);
        chk("t38_mstep", 64'(mstep), 64'd0);
        chk("t38_opcode", 64'(opcode), 64'h000);
        chk("t38_fetch_req", 64'(fetch_req), 64'd1);

        // page-1 entry with prefix bit set must execute, not fetch again
        drive(1, 8'hCB, 0, 1);
        drive(0, 8'h00, 0, 1);
        drive(1, 8'hAB, 0, 1);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t39_opcode", 64'(opcode), 64'h1AB);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t39_exec", 64'(ctrl_valid), 64'd1);
        chk("t39_no_fetch", 64'(fetch_req), 64'd0);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        chk("t39_refetch", 64'(fetch_req), 64'd1);

        // randomized traffic, checked only by the model
        for (int i = 0; i < 4000; i++) begin
            stall_pat = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom),
                  (stall_pat < 4'd5),
                  ($urandom_range(0, 149) != 0));
        end
        drive(0, 8'h00, 0, 1);
        drive(0, 8'h00, 0, 1);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
